channel_mixer_ctrl: RTL and testbench

//  Shares one quadrature encoder between NUM_CH colour channels. Consumes the

---
 rtl/channel_mixer_if.sv | 14 +
 rtl/channel_mixer_ctrl.sv | 94 +++++++++
 tb/tb_channel_mixer_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/channel_mixer_if.sv
// Encoder/button inputs and channel outputs of the channel mixer.
// The master side drives the encoder count and button; the slave side returns selection and channels.
interface channel_mixer_if #(
  parameter int NUM_CH = 3
);
  logic [7:0]          enc_value;
  logic                btn;
  logic [1:0]          sel;
  logic [8*NUM_CH-1:0] ch_values;
  logic                update;

  modport master (output enc_value, btn, input sel, ch_values, update);
  modport slave  (input enc_value, btn, output sel, ch_values, update);
endinterface

// File: rtl/channel_mixer_ctrl.sv
// Shares one free-running encoder count between NUM_CH 8-bit channel registers.
// A button press selects the next channel and briefly mutes encoder deltas.
module channel_mixer_ctrl #(
  parameter int         NUM_CH    = 3,
  parameter logic [7:0] RESET_VAL = 8'd0,
  parameter bit         SATURATE  = 1'b1,
  parameter int         HOLDOFF   = 4
) (
  input logic            clk,
  input logic            reset,
  channel_mixer_if.slave bus
);
  localparam logic [7:0] HOLDOFF_LD = 8'(HOLDOFF);
  localparam logic [1:0] LAST_SEL   = 2'(NUM_CH - 1);

  logic [7:0]              prev_r;
  logic [7:0]              holdoff_r;
  logic                    btn_q_r;
  logic [1:0]              sel_r;
  logic [NUM_CH-1:0][7:0]  ch_r;
  logic                    update_r;

  logic [7:0]        delta_s;
  logic [7:0]        cur_s;
  logic [7:0]        new_val_s;
  logic [7:0]        holdoff_nxt_s;
  logic signed [9:0] sum_s;
  logic              apply_s;
  logic              changed_s;
  logic              press_s;
  logic [1:0]        sel_nxt_s;

  // Signed encoder delta and the candidate new value of the selected channel
  always_comb begin
    delta_s = bus.enc_value - prev_r;
    apply_s = (delta_s != 8'd0) && (holdoff_r == 8'd0);
    cur_s   = 8'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      cur_s = (sel_r == 2'(k)) ? ch_r[k] : cur_s;
    end
    // 10-bit signed sum covers -128..382, so bits 9/8 flag under/overflow
    sum_s = $signed({2'b00, cur_s}) + $signed({{2{delta_s[7]}}, delta_s});
    if (SATURATE && sum_s[9]) begin
      new_val_s = 8'd0;
    end else if (SATURATE && sum_s[8]) begin
      new_val_s = 8'hFF;
    end else begin
      new_val_s = sum_s[7:0];
    end
    changed_s = apply_s && (new_val_s != cur_s);
  end

  // Button rising edge, selection advance and holdoff countdown
  always_comb begin
    press_s = bus.btn & ~btn_q_r;
    if (press_s) begin
      sel_nxt_s     = (sel_r == LAST_SEL) ? 2'd0 : sel_r + 2'd1;
      holdoff_nxt_s = HOLDOFF_LD;
    end else if (holdoff_r != 8'd0) begin
      sel_nxt_s     = sel_r;
      holdoff_nxt_s = holdoff_r - 8'd1;
    end else begin
      sel_nxt_s     = sel_r;
      holdoff_nxt_s = holdoff_r;
    end
  end

  // State registers; the delta lands on the selection held before any press this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r    <= bus.enc_value;
      btn_q_r   <= 1'b0;
      holdoff_r <= 8'd0;
      sel_r     <= 2'd0;
      ch_r      <= {NUM_CH{RESET_VAL}};
      update_r  <= 1'b0;
    end else begin
      prev_r    <= bus.enc_value;
      btn_q_r   <= bus.btn;
      holdoff_r <= holdoff_nxt_s;
      sel_r     <= sel_nxt_s;
      update_r  <= changed_s;
      for (int k = 0; k < NUM_CH; k++) begin
        if (changed_s && (sel_r == 2'(k))) begin
          ch_r[k] <= new_val_s;
        end
      end
    end
  end

  assign bus.sel       = sel_r;
  assign bus.ch_values = ch_r;
  assign bus.update    = update_r;
endmodule

// File: tb/tb_channel_mixer_ctrl.sv
// Table-driven bench: a saturating and a wrapping instance share one stimulus stream.
module tb_channel_mixer_ctrl;
  logic       clk;
  logic       rst;
  logic       btn;
  logic [7:0] enc;
  int         n_pass;
  int         n_total;

  channel_mixer_if #(.NUM_CH(3)) bus_s ();
  channel_mixer_if #(.NUM_CH(3)) bus_w ();

  assign bus_s.enc_value = enc;
  assign bus_s.btn       = btn;
  assign bus_w.enc_value = enc;
  assign bus_w.btn       = btn;

  channel_mixer_ctrl #(.NUM_CH(3), .RESET_VAL(8'd0), .SATURATE(1'b1), .HOLDOFF(4)) dut_sat (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_s)
  );

  channel_mixer_ctrl #(.NUM_CH(3), .RESET_VAL(8'd0), .SATURATE(1'b0), .HOLDOFF(4)) dut_wrap (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  enc;
    logic        btn;
    logic [1:0]  sel;
    logic [23:0] sch;
    logic        su;
    logic [23:0] wch;
    logic        wu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] e, input logic b, input logic [1:0] s,
                     input logic [23:0] sc, input logic su, input logic [23:0] wc, input logic wu);
    vec_t v;
    v.rst = r; v.enc = e; v.btn = b; v.sel = s;
    v.sch = sc; v.su = su; v.wch = wc; v.wu = wu;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] e, input logic b);
    rst = r;
    enc = e;
    btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic [1:0] s, input logic [23:0] sc,
                            input logic su, input logic [23:0] wc, input logic wu);
    check({tag, " sel_sat"},  32'(bus_s.sel),       32'(s));
    check({tag, " ch_sat"},   32'(bus_s.ch_values), 32'(sc));
    check({tag, " upd_sat"},  32'(bus_s.update),    32'(su));
    check({tag, " sel_wrap"}, 32'(bus_w.sel),       32'(s));
    check({tag, " ch_wrap"},  32'(bus_w.ch_values), 32'(wc));
    check({tag, " upd_wrap"}, 32'(bus_w.update),    32'(wu));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    enc     = 8'h37;
    btn     = 1'b0;

    // reset held, then a quiet cycle: prev was captured during reset
    add(1'b1, 8'h37, 1'b0, 2'd0, 24'h000000, 1'b0, 24'h000000, 1'b0);
    add(1'b1, 8'h37, 1'b0, 2'd0, 24'h000000, 1'b0, 24'h000000, 1'b0);
    add(1'b1, 8'h37, 1'b0, 2'd0, 24'h000000, 1'b0, 24'h000000, 1'b0);
    add(1'b0, 8'h37, 1'b0, 2'd0, 24'h000000, 1'b0, 24'h000000, 1'b0);
    // +5 into ch0, single-cycle update
    add(1'b0, 8'h3C, 1'b0, 2'd0, 24'h000005, 1'b1, 24'h000005, 1'b1);
    add(1'b0, 8'h3C, 1'b0, 2'd0, 24'h000005, 1'b0, 24'h000005, 1'b0);
    // press (held 2 cycles) -> sel 1; delta during holdoff is lost
    add(1'b0, 8'h3C, 1'b1, 2'd1, 24'h000005, 1'b0, 24'h000005, 1'b0);
    add(1'b0, 8'h3E, 1'b1, 2'd1, 24'h000005, 1'b0, 24'h000005, 1'b0);
    add(1'b0, 8'h3E, 1'b0, 2'd1, 24'h000005, 1'b0, 24'h000005, 1'b0);
    add(1'b0, 8'h3E, 1'b0, 2'd1, 24'h000005, 1'b0, 24'h000005, 1'b0);
    add(1'b0, 8'h3E, 1'b0, 2'd1, 24'h000005, 1'b0, 24'h000005, 1'b0);
    add(1'b0, 8'h41, 1'b0, 2'd1, 24'h000305, 1'b1, 24'h000305, 1'b1);
    // climb ch1 to 250 with +127 and +120, then overflow by +10 twice
    add(1'b0, 8'hC0, 1'b0, 2'd1, 24'h008205, 1'b1, 24'h008205, 1'b1);
    add(1'b0, 8'h38, 1'b0, 2'd1, 24'h00FA05, 1'b1, 24'h00FA05, 1'b1);
    add(1'b0, 8'h42, 1'b0, 2'd1, 24'h00FF05, 1'b1, 24'h000405, 1'b1);
    add(1'b0, 8'h4C, 1'b0, 2'd1, 24'h00FF05, 1'b0, 24'h000E05, 1'b1);
    // d = -128 and +127 extremes, then downward to underflow
    add(1'b0, 8'hCC, 1'b0, 2'd1, 24'h007F05, 1'b1, 24'h008E05, 1'b1);
    add(1'b0, 8'h4B, 1'b0, 2'd1, 24'h00FE05, 1'b1, 24'h000D05, 1'b1);
    add(1'b0, 8'h41, 1'b0, 2'd1, 24'h00F405, 1'b1, 24'h000305, 1'b1);
    add(1'b0, 8'h3C, 1'b0, 2'd1, 24'h00EF05, 1'b1, 24'h00FE05, 1'b1);
    add(1'b0, 8'hBC, 1'b0, 2'd1, 24'h006F05, 1'b1, 24'h007E05, 1'b1);
    add(1'b0, 8'h3C, 1'b0, 2'd1, 24'h000005, 1'b1, 24'h00FE05, 1'b1);
    add(1'b0, 8'h3B, 1'b0, 2'd1, 24'h000005, 1'b0, 24'h00FD05, 1'b1);
    // delta and press together: delta goes to old sel 1, then sel 2
    add(1'b0, 8'h3D, 1'b1, 2'd2, 24'h000205, 1'b1, 24'h00FF05, 1'b1);
    add(1'b0, 8'h3D, 1'b1, 2'd2, 24'h000205, 1'b0, 24'h00FF05, 1'b0);
    add(1'b0, 8'h40, 1'b0, 2'd2, 24'h000205, 1'b0, 24'h00FF05, 1'b0);
    add(1'b0, 8'h40, 1'b0, 2'd2, 24'h000205, 1'b0, 24'h00FF05, 1'b0);
    add(1'b0, 8'h40, 1'b0, 2'd2, 24'h000205, 1'b0, 24'h00FF05, 1'b0);
    add(1'b0, 8'h45, 1'b0, 2'd2, 24'h050205, 1'b1, 24'h05FF05, 1'b1);
    // last channel wraps selection back to 0
    add(1'b0, 8'h45, 1'b1, 2'd0, 24'h050205, 1'b0, 24'h05FF05, 1'b0);
    add(1'b0, 8'h45, 1'b0, 2'd0, 24'h050205, 1'b0, 24'h05FF05, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].enc, tbl[i].btn);
      check_both($sformatf("row%0d", i), tbl[i].sel, tbl[i].sch, tbl[i].su, tbl[i].wch, tbl[i].wu);
    end

    // three presses, each held 10 cycles: sel 1, 2, 0
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 10; c++) begin
        tick(1'b0, 8'h45, 1'b1);
      end
      check($sformatf("held%0d sel_sat", p), 32'(bus_s.sel), 32'((p + 1) % 3));
      check($sformatf("held%0d sel_wrap", p), 32'(bus_w.sel), 32'((p + 1) % 3));
      tick(1'b0, 8'h45, 1'b0);
    end

    // second press two cycles into holdoff reloads it
    tick(1'b0, 8'h45, 1'b1);
    tick(1'b0, 8'h45, 1'b0);
    tick(1'b0, 8'h45, 1'b1);
    check_both("reload_press", 2'd2, 24'h050205, 1'b0, 24'h05FF05, 1'b0);
    tick(1'b0, 8'h45, 1'b0);
    tick(1'b0, 8'h45, 1'b0);
    tick(1'b0, 8'h46, 1'b0);
    check_both("reload_mute", 2'd2, 24'h050205, 1'b0, 24'h05FF05, 1'b0);
    tick(1'b0, 8'h46, 1'b0);
    tick(1'b0, 8'h47, 1'b0);
    check_both("reload_done", 2'd2, 24'h060205, 1'b1, 24'h06FF05, 1'b1);

    // reset mid-holdoff clears selection and holdoff
    tick(1'b0, 8'h47, 1'b1);
    tick(1'b0, 8'h47, 1'b0);
    tick(1'b0, 8'h47, 1'b1);
    check_both("pre_reset", 2'd1, 24'h060205, 1'b0, 24'h06FF05, 1'b0);
    tick(1'b1, 8'h90, 1'b0);
    check_both("mid_reset", 2'd0, 24'h000000, 1'b0, 24'h000000, 1'b0);
    tick(1'b0, 8'h93, 1'b0);
    check_both("post_reset", 2'd0, 24'h000003, 1'b1, 24'h000003, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
